// File: rtl/n_cobs_decoder_pkg.sv
// Shared configuration and types for the nested n-COBS receive decoder.
package n_cobs_decoder_pkg;

   // Bytes of frame stack: pending outer prefixes plus the frame being collected.
   localparam int StackDepth          = 256;
   // Input skid FIFO depth; must be a power of 2.
   localparam int RxFifoDepth         = 16;
   // Width of the monotonic timestamp that leads every frame.
   localparam int MonoTimerWidthBytes = 4;
   localparam int HdrBytes            = MonoTimerWidthBytes;

   localparam int AddrW = $clog2(StackDepth);
   // One extra bit so chain arithmetic (pos - v, pos + v) can go negative.
   localparam int PtrW  = AddrW + 1;

   typedef logic signed [PtrW-1:0] StackPtrT;

   typedef enum logic [1:0] {
      COLLECT,
      WALK,
      EMIT,
      DISCARD
   } NCobsStateT;

   localparam StackPtrT PtrZero  = StackPtrT'(0);
   localparam StackPtrT PtrOne   = StackPtrT'(1);
   localparam StackPtrT HdrLimit = StackPtrT'(HdrBytes);

   // Offsets are 8-bit two's complement; widen to stack-pointer width.
   function automatic StackPtrT sext_offset(input logic [7:0] b);
      return {{(PtrW-8){b[7]}}, b};
   endfunction

endpackage

// File: rtl/n_cobs_decoder_if.sv
// Byte-stream bus of the decoder: raw RX bytes in, decoded frame bytes out.
interface n_cobs_decoder_if;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic       m_last_o;
   logic       m_hdr_o;

   // Decoder side.
   modport slave (
      input  rx_data_i, rx_valid_i, m_ready_i,
      output m_data_o, m_valid_o, m_last_o, m_hdr_o
   );

   // UART / sink side.
   modport master (
      output rx_data_i, rx_valid_i, m_ready_i,
      input  m_data_o, m_valid_o, m_last_o, m_hdr_o
   );
endinterface

// File: rtl/n_cobs_decoder_rx_fifo.sv
// Byte skid FIFO between the UART receiver and the decoder state machine.
module n_cobs_decoder_rx_fifo #(
   parameter int Depth = 16
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_empty,
   output logic       o_overrun
);

   localparam int AW = $clog2(Depth);
   localparam logic [AW:0] PtrInc = {{AW{1'b0}}, 1'b1};

   logic [7:0] r_mem [Depth];
   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   logic        w_full;
   logic        w_do_pop;
   logic        w_do_push;

   assign o_empty   = (r_wr == r_rd);
   assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still accepts a byte in the cycle a byte leaves it.
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_overrun = i_push && !w_do_push;
   assign o_data    = r_mem[r_rd[AW-1:0]];

   // Read/write pointers; reset empties the FIFO.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PtrInc;
         if (w_do_pop)  r_rd <= r_rd + PtrInc;
      end
   end

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/n_cobs_decoder.sv
// Nested n-COBS decoder: stacks frame bytes, walks the backward offset chain
// to restore zeros, then streams the innermost complete frame out.
module n_cobs_decoder
   import n_cobs_decoder_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_ni,
   n_cobs_decoder_if.slave bus,
   output logic            err_overrun_o,
   output logic            err_overflow_o,
   output logic            err_format_o
);

   localparam logic [PtrW-1:0] WpOne  = PtrW'(1);
   localparam logic [PtrW-1:0] WpFull = PtrW'(StackDepth);

   NCobsStateT      r_state, w_state_nxt;
   logic [PtrW-1:0] r_wp, w_wp_nxt;
   StackPtrT        r_pos, w_pos_nxt;
   StackPtrT        r_tail, w_tail_nxt;
   StackPtrT        r_start, w_start_nxt;
   StackPtrT        r_idx, w_idx_nxt;

   logic [7:0]       r_buf [StackDepth];
   logic             w_buf_we;
   logic [AddrW-1:0] w_buf_waddr;
   logic [7:0]       w_buf_wdata;

   logic       w_fifo_pop;
   logic       w_fifo_empty;
   logic       w_fifo_overrun;
   logic [7:0] w_fifo_data;

   logic w_err_overflow, w_err_format;
   logic r_err_overrun, r_err_overflow, r_err_format;

   StackPtrT w_v, w_t, w_s, w_tail_m1, w_hdr_off;
   logic     w_emit, w_last;

   n_cobs_decoder_rx_fifo #(.Depth(RxFifoDepth)) u_rx_fifo (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .i_push    (bus.rx_valid_i),
      .i_data    (bus.rx_data_i),
      .i_pop     (w_fifo_pop),
      .o_data    (w_fifo_data),
      .o_empty   (w_fifo_empty),
      .o_overrun (w_fifo_overrun)
   );

   assign w_v       = sext_offset(r_buf[r_pos[AddrW-1:0]]);
   assign w_t       = r_pos - w_v;
   assign w_tail_m1 = r_tail - PtrOne;
   assign w_hdr_off = r_idx - r_start;
   assign w_emit    = (r_state == EMIT);
   assign w_last    = (r_idx == w_tail_m1);

   // Output flags are forced low outside EMIT so reset clears them at once.
   assign bus.m_valid_o = w_emit;
   assign bus.m_data_o  = w_emit ? r_buf[r_idx[AddrW-1:0]] : 8'h00;
   assign bus.m_last_o  = w_emit && w_last;
   assign bus.m_hdr_o   = w_emit && (w_hdr_off < HdrLimit);

   assign err_overrun_o  = r_err_overrun;
   assign err_overflow_o = r_err_overflow;
   assign err_format_o   = r_err_format;

   // Next-state, stack write port and error strobes.
   always_comb begin
      w_state_nxt    = r_state;
      w_wp_nxt       = r_wp;
      w_pos_nxt      = r_pos;
      w_tail_nxt     = r_tail;
      w_start_nxt    = r_start;
      w_idx_nxt      = r_idx;
      w_buf_we       = 1'b0;
      w_buf_waddr    = r_wp[AddrW-1:0];
      w_buf_wdata    = w_fifo_data;
      w_fifo_pop     = 1'b0;
      w_err_overflow = 1'b0;
      w_err_format   = 1'b0;
      w_s            = PtrZero;
      case (r_state)
         COLLECT: begin
            if (!w_fifo_empty) begin
               w_fifo_pop = 1'b1;
               if (w_fifo_data != 8'h00) begin
                  if (r_wp == WpFull) begin
                     w_err_overflow = 1'b1;
                     w_state_nxt    = DISCARD;
                  end else begin
                     w_buf_we = 1'b1;
                     w_wp_nxt = r_wp + WpOne;
                  end
               end else if (r_wp != '0) begin
                  // Sentinel closes the frame; its last byte heads the chain.
                  w_pos_nxt   = StackPtrT'(r_wp - WpOne);
                  w_tail_nxt  = StackPtrT'(r_wp - WpOne);
                  w_state_nxt = WALK;
               end
            end
         end
         WALK: begin
            w_buf_waddr = r_pos[AddrW-1:0];
            w_buf_wdata = 8'h00;
            if (w_v > PtrZero) begin
               if (w_t < PtrZero) begin
                  w_err_format = 1'b1;
               end else begin
                  // The tail holds the first offset, not payload: leave it.
                  w_buf_we  = (r_pos != r_tail);
                  w_pos_nxt = w_t;
               end
            end else begin
               if (r_pos == r_tail) begin
                  w_s = r_pos + w_v;
               end else if (w_v != PtrZero) begin
                  w_buf_we = 1'b1;
                  w_s      = r_pos + w_v + PtrOne;
               end else begin
                  w_err_format = 1'b1;
               end
               if (!w_err_format) begin
                  if (w_s < PtrZero) begin
                     w_err_format = 1'b1;
                  end else if (w_s == r_tail) begin
                     w_wp_nxt    = w_s;
                     w_state_nxt = COLLECT;
                  end else begin
                     w_start_nxt = w_s;
                     w_idx_nxt   = w_s;
                     w_state_nxt = EMIT;
                  end
               end
            end
            if (w_err_format) begin
               w_buf_we    = 1'b0;
               w_wp_nxt    = '0;
               w_state_nxt = COLLECT;
            end
         end
         EMIT: begin
            if (bus.m_ready_i) begin
               if (w_last) begin
                  // Pop the inner frame; the preempted prefix stays below start.
                  w_wp_nxt    = r_start;
                  w_state_nxt = COLLECT;
               end else begin
                  w_idx_nxt = r_idx + PtrOne;
               end
            end
         end
         DISCARD: begin
            if (!w_fifo_empty) begin
               w_fifo_pop = 1'b1;
               if (w_fifo_data == 8'h00) begin
                  w_wp_nxt    = '0;
                  w_state_nxt = COLLECT;
               end
            end
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   // FSM state and stack pointers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= COLLECT;
         r_wp    <= '0;
         r_pos   <= PtrZero;
         r_tail  <= PtrZero;
         r_start <= PtrZero;
         r_idx   <= PtrZero;
      end else begin
         r_state <= w_state_nxt;
         r_wp    <= w_wp_nxt;
         r_pos   <= w_pos_nxt;
         r_tail  <= w_tail_nxt;
         r_start <= w_start_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Frame stack, one write per cycle; contents are meaningless above wp.
   always_ff @(posedge clk_i) begin
      if (w_buf_we) r_buf[w_buf_waddr] <= w_buf_wdata;
   end

   // Registered single-cycle error pulses.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_err_overrun  <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_format   <= 1'b0;
      end else begin
         r_err_overrun  <= w_fifo_overrun;
         r_err_overflow <= w_err_overflow;
         r_err_format   <= w_err_format;
      end
   end

endmodule

// File: tb/tb_n_cobs_decoder.sv
// Directed bench for the nested n-COBS decoder.
module tb_n_cobs_decoder;
   import n_cobs_decoder_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic eo, ef, efm;

   n_cobs_decoder_if bus();

   n_cobs_decoder u_dut (
      .clk_i          (clk),
      .reset_ni       (rst_n),
      .bus            (bus),
      .err_overrun_o  (eo),
      .err_overflow_o (ef),
      .err_format_o   (efm)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int miscmp = 0;

   // Beats are {last, hdr, data}.
   logic [9:0] rxq[$];
   int cnt_ovr = 0, cnt_ovf = 0, cnt_fmt = 0, hold_viol = 0;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_beat = '0;

   logic [7:0] f1 [7] = '{8'hFF, 8'h01, 8'h01, 8'h05, 8'h41, 8'h03, 8'h00};
   logic [9:0] exp_f1 [5] = '{10'h100, 10'h100, 10'h100, 10'h105, 10'h241};
   logic [7:0] fn [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h01, 8'h01,
                           8'h07, 8'h02, 8'h00, 8'h55, 8'hFB, 8'h00};
   logic [9:0] exp_fn [9] = '{10'h100, 10'h100, 10'h100, 10'h307,
                              10'h101, 10'h102, 10'h103, 10'h104, 10'h255};

   // Negedge monitor: collects handshakes, counts error pulses, checks hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (!bus.m_valid_o ||
             {bus.m_last_o, bus.m_hdr_o, bus.m_data_o} !== prev_beat))
            hold_viol <= hold_viol + 1;
         if (bus.m_valid_o && bus.m_ready_i)
            rxq.push_back({bus.m_last_o, bus.m_hdr_o, bus.m_data_o});
         prev_stall <= bus.m_valid_o && !bus.m_ready_i;
         prev_beat  <= {bus.m_last_o, bus.m_hdr_o, bus.m_data_o};
         if (eo)  cnt_ovr <= cnt_ovr + 1;
         if (ef)  cnt_ovf <= cnt_ovf + 1;
         if (efm) cnt_fmt <= cnt_fmt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic send_f1();
      for (int i = 0; i < 7; i++) send_byte(f1[i]);
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (rxq.size() < n && k < budget) begin
         tick(1);
         k++;
      end
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!bus.m_valid_o && k < budget) begin
         tick(1);
         k++;
      end
   endtask

   task automatic test_reset();
      bus.rx_data_i  = 8'h00;
      bus.rx_valid_i = 1'b0;
      bus.m_ready_i  = 1'b0;
      rst_n = 1'b0;
      tick(3);
      vec++;
      if (bus.m_valid_o !== 1'b0) begin
         miscmp++;
         $display("FAIL reset_valid_in_reset got %b want 0", bus.m_valid_o);
      end
      rst_n = 1'b1;
      tick(2);
      @(negedge clk);
      vec++;
      if (bus.m_valid_o !== 1'b0) begin
         miscmp++;
         $display("FAIL reset_valid got %b want 0", bus.m_valid_o);
      end
      vec++;
      if ({bus.m_last_o, bus.m_hdr_o, bus.m_data_o} !== 10'h000) begin
         miscmp++;
         $display("FAIL reset_outputs got %h want 000", {bus.m_last_o, bus.m_hdr_o, bus.m_data_o});
      end
      vec++;
      if ({eo, ef, efm} !== 3'b000) begin
         miscmp++;
         $display("FAIL reset_errors got %b want 000", {eo, ef, efm});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      logic [9:0] got;
      rxq.delete();
      bus.m_ready_i = 1'b1;
      send_f1();
      wait_beats(5, 100);
      tick(10);
      vec++;
      if (rxq.size() !== 5) begin
         miscmp++;
         $display("FAIL single_count got %0d want 5", rxq.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i]) begin
            miscmp++;
            $display("FAIL single_beat%0d got %h want %h", i, got, exp_f1[i]);
         end
      end
   endtask

   task automatic test_nested();
      logic [9:0] got;
      rxq.delete();
      bus.m_ready_i = 1'b1;
      for (int i = 0; i < 13; i++) send_byte(fn[i]);
      wait_beats(9, 200);
      tick(10);
      vec++;
      if (rxq.size() !== 9) begin
         miscmp++;
         $display("FAIL nested_count got %0d want 9", rxq.size());
      end
      for (int i = 0; i < 9; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_fn[i]) begin
            miscmp++;
            $display("FAIL nested_beat%0d got %h want %h", i, got, exp_fn[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] got;
      int ovr0;
      rxq.delete();
      fork
         begin
            send_f1();
            wait_beats(5, 200);
         end
         begin
            for (int i = 0; i < 60; i++) begin
               bus.m_ready_i = i[0];
               tick(1);
            end
         end
      join
      vec++;
      if (rxq.size() !== 5) begin
         miscmp++;
         $display("FAIL bp_count got %0d want 5", rxq.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i]) begin
            miscmp++;
            $display("FAIL bp_beat%0d got %h want %h", i, got, exp_f1[i]);
         end
      end
      // Hold output, fill the FIFO with 16 bytes, the 17th must overrun.
      rxq.delete();
      bus.m_ready_i = 1'b0;
      ovr0 = cnt_ovr;
      send_f1();
      wait_valid(50);
      vec++;
      if (bus.m_valid_o !== 1'b1) begin
         miscmp++;
         $display("FAIL bp_first_valid got %b want 1", bus.m_valid_o);
      end
      send_f1();
      send_f1();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h77);
      tick(3);
      vec++;
      if (cnt_ovr - ovr0 !== 1) begin
         miscmp++;
         $display("FAIL bp_overrun_pulses got %0d want 1", cnt_ovr - ovr0);
      end
      vec++;
      if (rxq.size() !== 0) begin
         miscmp++;
         $display("FAIL bp_stalled_beats got %0d want 0", rxq.size());
      end
      bus.m_ready_i = 1'b1;
      wait_beats(15, 300);
      tick(10);
      vec++;
      if (rxq.size() !== 15) begin
         miscmp++;
         $display("FAIL bp_fifo_count got %0d want 15", rxq.size());
      end
      for (int i = 0; i < 15; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i % 5]) begin
            miscmp++;
            $display("FAIL bp_fifo_beat%0d got %h want %h", i, got, exp_f1[i % 5]);
         end
      end
      vec++;
      if (hold_viol !== 0) begin
         miscmp++;
         $display("FAIL bp_hold_stable got %0d violations want 0", hold_viol);
      end
   endtask

   task automatic test_bad_chain();
      logic [9:0] got;
      int fmt0;
      rxq.delete();
      bus.m_ready_i = 1'b1;
      fmt0 = cnt_fmt;
      send_byte(8'h01);
      send_byte(8'h7F);
      send_byte(8'h00);
      tick(20);
      vec++;
      if (cnt_fmt - fmt0 !== 1) begin
         miscmp++;
         $display("FAIL badchain_pulses got %0d want 1", cnt_fmt - fmt0);
      end
      vec++;
      if (rxq.size() !== 0) begin
         miscmp++;
         $display("FAIL badchain_output got %0d beats want 0", rxq.size());
      end
      send_f1();
      wait_beats(5, 100);
      tick(10);
      vec++;
      if (rxq.size() !== 5) begin
         miscmp++;
         $display("FAIL badchain_recover_count got %0d want 5", rxq.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i]) begin
            miscmp++;
            $display("FAIL badchain_recover_beat%0d got %h want %h", i, got, exp_f1[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [9:0] got;
      int ovf0;
      rxq.delete();
      bus.m_ready_i = 1'b1;
      ovf0 = cnt_ovf;
      for (int i = 0; i < StackDepth + 1; i++) send_byte(8'h11);
      send_byte(8'h00);
      tick(10);
      vec++;
      if (cnt_ovf - ovf0 !== 1) begin
         miscmp++;
         $display("FAIL overflow_pulses got %0d want 1", cnt_ovf - ovf0);
      end
      vec++;
      if (rxq.size() !== 0) begin
         miscmp++;
         $display("FAIL overflow_output got %0d beats want 0", rxq.size());
      end
      send_f1();
      wait_beats(5, 100);
      tick(10);
      vec++;
      if (rxq.size() !== 5) begin
         miscmp++;
         $display("FAIL overflow_recover_count got %0d want 5", rxq.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i]) begin
            miscmp++;
            $display("FAIL overflow_recover_beat%0d got %h want %h", i, got, exp_f1[i]);
         end
      end
   endtask

   task automatic test_lone_sentinels();
      int e0;
      rxq.delete();
      bus.m_ready_i = 1'b1;
      e0 = cnt_ovr + cnt_ovf + cnt_fmt;
      send_byte(8'h00);
      send_byte(8'h00);
      tick(10);
      vec++;
      if (rxq.size() !== 0) begin
         miscmp++;
         $display("FAIL lone_output got %0d beats want 0", rxq.size());
      end
      vec++;
      if (cnt_ovr + cnt_ovf + cnt_fmt - e0 !== 0) begin
         miscmp++;
         $display("FAIL lone_errors got %0d pulses want 0", cnt_ovr + cnt_ovf + cnt_fmt - e0);
      end
   endtask

   task automatic test_reset_mid_emit();
      logic [9:0] got;
      rxq.delete();
      bus.m_ready_i = 1'b0;
      send_f1();
      wait_valid(50);
      vec++;
      if (bus.m_valid_o !== 1'b1) begin
         miscmp++;
         $display("FAIL rstmid_valid_before got %b want 1", bus.m_valid_o);
      end
      rst_n = 1'b0;
      #1;
      vec++;
      if (bus.m_valid_o !== 1'b0) begin
         miscmp++;
         $display("FAIL rstmid_valid_async got %b want 0", bus.m_valid_o);
      end
      tick(2);
      rst_n = 1'b1;
      tick(2);
      bus.m_ready_i = 1'b1;
      tick(10);
      vec++;
      if (rxq.size() !== 0) begin
         miscmp++;
         $display("FAIL rstmid_flushed got %0d beats want 0", rxq.size());
      end
      send_f1();
      wait_beats(5, 100);
      tick(10);
      vec++;
      if (rxq.size() !== 5) begin
         miscmp++;
         $display("FAIL rstmid_recover_count got %0d want 5", rxq.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < rxq.size()) ? rxq[i] : 10'h3FF;
         vec++;
         if (got !== exp_f1[i]) begin
            miscmp++;
            $display("FAIL rstmid_recover_beat%0d got %h want %h", i, got, exp_f1[i]);
         end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_nested();
      test_backpressure();
      test_bad_chain();
      test_overflow();
      test_lone_sentinels();
      test_reset_mid_emit();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
